// File: rtl/axil_mmio_master.sv
// axil_mmio_master: single-outstanding AXI4-Lite master bridge.
// Turns the core's load/store request port into one AXI4-Lite read or
// write at a time. AW and W are issued together; B/R are only taken once
// the address (and write data) phases have completed.
// Optional feature macro: AXIL_MST_TIMEOUT_EN (per-transaction timeout).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction in flight, req_ready=1
// ST_WR   | write in flight: AW/W until handshaken, B accepted after both
// ST_RD   | read in flight: AR until handshaken, R accepted after AR
module axil_mmio_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("axil_mmio_master: TIMEOUT_CYCLES out of range 2..65535");
        end
    endgenerate

    state_t      state_q, state_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d, ar_done_q, ar_done_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic        unused_resp_lsb;

`ifdef AXIL_MST_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    // Only resp[1] distinguishes error from OK.
    assign unused_resp_lsb = m_bresp[0] ^ m_rresp[0];

    // Channel handshakes; B/R only count once the request phases are done.
    assign aw_hs = awvalid_q & m_awready;
    assign w_hs  = wvalid_q & m_wready;
    assign ar_hs = arvalid_q & m_arready;
    assign b_hs  = bready_q & m_bvalid & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign r_hs  = rready_q & m_rvalid & (ar_done_q | ar_hs);

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        ar_done_d   = ar_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef AXIL_MST_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[31:2], 2'b00};
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
`ifdef AXIL_MST_TIMEOUT_EN
                    cnt_d   = 16'd0;
`endif
                    if (req_we) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RD;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        ar_done_d = 1'b0;
                    end
                end
            end
            ST_WR: begin
                awvalid_d = awvalid_q & ~m_awready;
                wvalid_d  = wvalid_q & ~m_wready;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (b_hs) begin
                    state_d     = ST_IDLE;
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = m_bresp[1];
                    rsp_rdata_d = 32'h0;
                end
`ifdef AXIL_MST_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d     = ST_IDLE;
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'hDEAD_BEEF;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_RD: begin
                arvalid_d = arvalid_q & ~m_arready;
                ar_done_d = ar_done_q | ar_hs;
                if (r_hs) begin
                    state_d     = ST_IDLE;
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = m_rresp[1];
                    rsp_rdata_d = m_rdata;
                end
`ifdef AXIL_MST_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d     = ST_IDLE;
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'hDEAD_BEEF;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            ar_done_q   <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
`ifdef AXIL_MST_TIMEOUT_EN
            cnt_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            ar_done_q   <= ar_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef AXIL_MST_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_awaddr  = addr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_axil_mmio_master.sv
// Testbench for axil_mmio_master: a configurable AXI-Lite slave with
// per-channel ready/response delays, a channel monitor, and a reference
// latency/response model derived from the handshake rules.
module tb_axil_mmio_master;
`ifdef AXIL_MST_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    int errors = 0;
    int checks = 0;

    // slave configuration
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    logic        cfg_early = 1'b0;

    // monitor state
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] ar_q[$];
    int overlap_cnt = 0, stab_cnt = 0, aw_cyc = 0, w_cyc = 0;

    axil_mmio_master #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    // Slave: drives its outputs at negedge from what the master shows.
    initial begin : slave
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic aw_got, w_got, ar_got;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rstn || !m_bready) begin
                aw_got = 0; w_got = 0;
                aw_cnt = cfg_aw_dly; w_cnt = cfg_w_dly; b_cnt = cfg_b_dly;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
            end else begin
                if (m_awready) aw_got = 1;
                if (m_wready)  w_got = 1;
                if (m_awvalid && !aw_got) begin
                    m_awready = (aw_cnt == 0);
                    if (aw_cnt > 0) aw_cnt--;
                end else m_awready = 0;
                if (m_wvalid && !w_got) begin
                    m_wready = (w_cnt == 0);
                    if (w_cnt > 0) w_cnt--;
                end else m_wready = 0;
                if ((aw_got || m_awready) && (w_got || m_wready)) begin
                    if (b_cnt == 0) begin m_bvalid = 1; m_bresp = cfg_bresp; end
                    else begin b_cnt--; m_bvalid = 0; end
                end else begin
                    m_bvalid = cfg_early; m_bresp = 2'b00;
                end
            end
            if (!rstn || !m_rready) begin
                ar_got = 0; ar_cnt = cfg_ar_dly; r_cnt = cfg_r_dly;
                m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
            end else begin
                if (m_arready) ar_got = 1;
                if (m_arvalid && !ar_got) begin
                    m_arready = (ar_cnt == 0);
                    if (ar_cnt > 0) ar_cnt--;
                end else m_arready = 0;
                if (ar_got || m_arready) begin
                    if (r_cnt == 0) begin m_rvalid = 1; m_rdata = cfg_rdata; m_rresp = cfg_rresp; end
                    else begin r_cnt--; m_rvalid = 0; end
                end else begin
                    m_rvalid = cfg_early; m_rdata = 32'hBAD0_0BAD; m_rresp = ~cfg_rresp;
                end
            end
        end
    end

    // Monitor: records handshakes, channel overlap and valid/payload stability.
    logic        hold_aw = 0, hold_w = 0, hold_ar = 0;
    logic [31:0] held_aw, held_ar;
    logic [35:0] held_w;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_aw = 0; hold_w = 0; hold_ar = 0;
        end else begin
            if (m_awvalid && m_awready) aw_q.push_back(m_awaddr);
            if (m_wvalid && m_wready)   w_q.push_back({m_wstrb, m_wdata});
            if (m_arvalid && m_arready) ar_q.push_back(m_araddr);
            if (m_awvalid) aw_cyc++;
            if (m_wvalid)  w_cyc++;
            if ((m_awvalid | m_wvalid | m_bready) && (m_arvalid | m_rready)) overlap_cnt++;
            if (hold_aw && (!m_awvalid || m_awaddr !== held_aw)) stab_cnt++;
            if (hold_w && (!m_wvalid || {m_wstrb, m_wdata} !== held_w)) stab_cnt++;
            if (hold_ar && (!m_arvalid || m_araddr !== held_ar)) stab_cnt++;
            hold_aw = m_awvalid && !m_awready; held_aw = m_awaddr;
            hold_w  = m_wvalid && !m_wready;   held_w  = {m_wstrb, m_wdata};
            hold_ar = m_arvalid && !m_arready; held_ar = m_araddr;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void clear_mon();
        aw_q.delete(); w_q.delete(); ar_q.delete();
        aw_cyc = 0; w_cyc = 0;
    endfunction

    // Reference model: edges after the accept edge until rsp_valid is seen.
    function automatic int model_lat(input logic we);
        int l;
        if (we) l = 1 + ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly) + cfg_b_dly;
        else    l = 1 + cfg_ar_dly + cfg_r_dly;
`ifdef AXIL_MST_TIMEOUT_EN
        if (l > TB_TO) l = TB_TO;
`endif
        return l;
    endfunction

    // Issue one request, observe its response (no checking here).
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, output int lat, output logic [31:0] rd,
                         output logic er, output logic pulse_ok);
        int g;
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st;
        g = 0;
        while (!req_ready && g < 200) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        req_valid = 0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 3000);
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata; er = rsp_err;
        @(posedge clk); #1;
        pulse_ok = !rsp_valid && (rsp_rdata === rd) && (rsp_err === er);
    endtask

    task automatic test_reset();
        rstn = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        #12;
        checks++;
        if ({req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b e=%b d=%h want zeros", rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if ({m_awaddr, m_wdata, m_wstrb} !== 68'h0) begin
            errors++;
            $display("FAIL reset_payload: got aw=%h w=%h s=%h want zeros", m_awaddr, m_wdata, m_wstrb);
        end
        @(negedge clk); rstn = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_telemetry_read();
        int lat; logic [31:0] rd; logic er, pok;
        logic [63:0] minstret;
        minstret = 64'h0000_0001_1234_5678;
        cfg_ar_dly = 0; cfg_r_dly = 0; cfg_rresp = 2'b00; cfg_early = 0;
        cfg_rdata = minstret[31:0];
        clear_mon();
        issue(1'b0, 32'h8000_1008, 32'h0, 4'h0, lat, rd, er, pok);
        checks++;
        if (ar_q.size() != 1 || ar_q[0] !== 32'h8000_1008) begin
            errors++;
            $display("FAIL telem_araddr: got n=%0d a=%h want 80001008", ar_q.size(),
                     (ar_q.size() > 0) ? ar_q[0] : 32'h0);
        end
        checks++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin
            errors++; $display("FAIL telem_rsp: got d=%h e=%b want 12345678 0", rd, er);
        end
        checks++;
        if (lat != 1 || !pok) begin
            errors++; $display("FAIL telem_timing: got lat=%0d pulse_ok=%b want 1 1", lat, pok);
        end
    endtask

    task automatic test_delayed_write();
        int lat; logic [31:0] rd; logic er, pok;
        cfg_aw_dly = 3; cfg_w_dly = 0; cfg_b_dly = 1; cfg_bresp = 2'b01; cfg_early = 0;
        clear_mon();
        issue(1'b1, 32'h8000_0003, 32'hA5A5_A5A5, 4'b0011, lat, rd, er, pok);
        checks++;
        if (aw_q.size() != 1 || aw_q[0] !== 32'h8000_0000) begin
            errors++; $display("FAIL wr_awaddr: got n=%0d want one at 80000000", aw_q.size());
        end
        checks++;
        if (w_q.size() != 1 || w_q[0] !== {4'b0011, 32'hA5A5_A5A5}) begin
            errors++; $display("FAIL wr_wdata: got n=%0d want one 3_a5a5a5a5", w_q.size());
        end
        checks++;
        if (w_cyc != 1 || aw_cyc != 4) begin
            errors++; $display("FAIL wr_valid_cycles: got w=%0d aw=%0d want 1 4", w_cyc, aw_cyc);
        end
        checks++;
        if (lat != 5 || rd !== 32'h0 || er !== 1'b0 || !pok) begin
            errors++; $display("FAIL wr_rsp: got lat=%0d d=%h e=%b p=%b want 5 0 0 1", lat, rd, er, pok);
        end
    endtask

    task automatic test_err_and_early();
        int lat; logic [31:0] rd, v; logic er, pok;
        v = $urandom;
        cfg_ar_dly = 1; cfg_r_dly = 1; cfg_rresp = 2'b10; cfg_rdata = v; cfg_early = 1;
        issue(1'b0, 32'h4000_0010, 32'h0, 4'h0, lat, rd, er, pok);
        checks++;
        if (lat != 3 || rd !== v || er !== 1'b1) begin
            errors++; $display("FAIL rd_slverr: got lat=%0d d=%h e=%b want 3 %h 1", lat, rd, er, v);
        end
        cfg_aw_dly = 3; cfg_w_dly = 1; cfg_b_dly = 0; cfg_bresp = 2'b11;
        clear_mon();
        issue(1'b1, 32'h4000_0020, $urandom, 4'hF, lat, rd, er, pok);
        checks++;
        if (lat != 4 || er !== 1'b1 || rd !== 32'h0 || aw_q.size() != 1 || w_q.size() != 1) begin
            errors++;
            $display("FAIL wr_early_b: got lat=%0d e=%b d=%h aw=%0d w=%0d want 4 1 0 1 1",
                     lat, er, rd, aw_q.size(), w_q.size());
        end
        cfg_early = 0;
    endtask

    task automatic test_back_to_back();
        int n, g; logic [31:0] a1, a2, v;
        a1 = $urandom; a2 = $urandom; v = $urandom;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = v;
        clear_mon();
        overlap_cnt = 0;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = a1; req_wdata = $urandom; req_wstrb = 4'hF;
        g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        req_we = 0; req_addr = a2;
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 1 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL b2b_first: got lat=%0d ready=%b d=%h want 1 1 0", n, req_ready, rsp_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if ({req_ready, m_arvalid, m_awvalid} !== 3'b010) begin
            errors++; $display("FAIL b2b_accept: got %b want 010", {req_ready, m_arvalid, m_awvalid});
        end
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 1 || rsp_rdata !== v) begin
            errors++; $display("FAIL b2b_second: got lat=%0d d=%h want 1 %h", n, rsp_rdata, v);
        end
        checks++;
        if (overlap_cnt != 0 || aw_q.size() != 1 || ar_q.size() != 1 ||
            aw_q[0] !== {a1[31:2], 2'b00} || ar_q[0] !== {a2[31:2], 2'b00}) begin
            errors++;
            $display("FAIL b2b_channels: got overlap=%0d aw=%0d ar=%0d want 0 1 1 with aligned addrs",
                     overlap_cnt, aw_q.size(), ar_q.size());
        end
    endtask

    task automatic test_random();
        int lat, el; logic [31:0] rd, a, wd, erd; logic er, pok, we, eer; logic [3:0] st;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom); a = $urandom; wd = $urandom; st = 4'($urandom);
            cfg_aw_dly = $urandom_range(0, 2); cfg_w_dly = $urandom_range(0, 2);
            cfg_b_dly = $urandom_range(0, 2); cfg_ar_dly = $urandom_range(0, 2);
            cfg_r_dly = $urandom_range(0, 2);
            cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom); cfg_rdata = $urandom;
            cfg_early = 1'($urandom);
            el = model_lat(we);
            erd = we ? 32'h0 : cfg_rdata;
            eer = we ? cfg_bresp[1] : cfg_rresp[1];
            clear_mon();
            issue(we, a, wd, st, lat, rd, er, pok);
            checks++;
            if (lat != el || rd !== erd || er !== eer || !pok) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: got lat=%0d d=%h e=%b p=%b want %0d %h %b 1",
                         i, lat, rd, er, pok, el, erd, eer);
            end
            checks++;
            if (we ? (aw_q.size() != 1 || w_q.size() != 1 || ar_q.size() != 0 ||
                      aw_q[0] !== {a[31:2], 2'b00} || w_q[0] !== {st, wd})
                   : (ar_q.size() != 1 || aw_q.size() != 0 || w_q.size() != 0 ||
                      ar_q[0] !== {a[31:2], 2'b00})) begin
                errors++;
                $display("FAIL rand_chan[%0d]: got aw=%0d w=%0d ar=%0d want single %s handshake",
                         i, aw_q.size(), w_q.size(), ar_q.size(), we ? "write" : "read");
            end
        end
        cfg_early = 0;
    endtask

    task automatic test_reset_mid_read();
        int lat, g, seen; logic [31:0] rd; logic er, pok;
        cfg_ar_dly = 0; cfg_r_dly = 0; cfg_rresp = 2'b00; cfg_rdata = 32'hCAFE_F00D;
        issue(1'b0, 32'h8000_1000, 32'h0, 4'h0, lat, rd, er, pok);
        cfg_ar_dly = 100;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 32'h8000_1004;
        g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk); #1; req_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_arvalid, m_rready, rsp_rdata} !== {2'b11, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL rst_pre: got arv=%b rr=%b d=%h want 1 1 cafef00d", m_arvalid, m_rready, rsp_rdata);
        end
        #1; rstn = 0; #1;
        checks++;
        if ({m_arvalid, m_rready, req_ready, rsp_valid, rsp_rdata} !== {4'b0010, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid: got arv=%b rr=%b rdy=%b v=%b d=%h want 0 0 1 0 0",
                     m_arvalid, m_rready, req_ready, rsp_valid, rsp_rdata);
        end
        @(negedge clk); @(negedge clk); rstn = 1;
        cfg_ar_dly = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rsp_valid || !req_ready) seen++; end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rst_quiet: got %0d busy/rsp cycles want 0", seen);
        end
        cfg_rdata = 32'h0BAD_F00D ^ 32'($urandom);
        issue(1'b0, 32'h8000_1004, 32'h0, 4'h0, lat, rd, er, pok);
        checks++;
        if (lat != 1 || rd !== cfg_rdata || er !== 1'b0) begin
            errors++; $display("FAIL rst_recover: got lat=%0d d=%h e=%b want 1 %h 0", lat, rd, er, cfg_rdata);
        end
    endtask

`ifdef AXIL_MST_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic [31:0] rd; logic er, pok;
        cfg_ar_dly = 1000; cfg_r_dly = 0; cfg_rdata = 32'h1111_2222; cfg_rresp = 2'b00;
        clear_mon();
        issue(1'b0, 32'h8000_1008, 32'h0, 4'h0, lat, rd, er, pok);
        checks++;
        if (lat != TB_TO || rd !== 32'hDEAD_BEEF || er !== 1'b1 || !pok || ar_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: got lat=%0d d=%h e=%b p=%b ar=%0d want %0d deadbeef 1 1 0",
                     lat, rd, er, pok, ar_q.size(), TB_TO);
        end
        cfg_ar_dly = 0;
        issue(1'b0, 32'h8000_1008, 32'h0, 4'h0, lat, rd, er, pok);
        checks++;
        if (lat != 1 || rd !== 32'h1111_2222 || er !== 1'b0) begin
            errors++; $display("FAIL timeout_recover: got lat=%0d d=%h e=%b want 1 11112222 0", lat, rd, er);
        end
    endtask
`endif

    task automatic test_protocol();
        checks++;
        if (stab_cnt != 0) begin
            errors++; $display("FAIL axi_stability: got %0d violations want 0", stab_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_telemetry_read();
        test_delayed_write();
        test_err_and_early();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
`ifdef AXIL_MST_TIMEOUT_EN
        test_timeout();
`endif
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
